// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse-sequencer family.
// States, default parameter values and nominal timing constants at 40 MHz.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    COOL = 2'd3
  } state_e;

  localparam int unsigned DEF_NPULSE_MAX = 4;
  localparam int unsigned DEF_CNT_W      = 32;
  localparam int unsigned DEF_DT_W       = 10;
  localparam logic [3:0]  DEF_GATE_MASK  = 4'b1110;

  localparam int unsigned DEAD_7US = 280;
  localparam int unsigned COOL_5S  = 200_000_000;

endpackage

// File: rtl/deadtime_ramp.sv
// Dead-time interlock: a saturating up/down ramp that only lets the high side on when
// fully charged and the low side on when fully discharged.
module deadtime_ramp
  import pulse_gen_pkg::*;
#(
  parameter int unsigned DT_W = DEF_DT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd,
  input  logic [DT_W-1:0] dead_cyc,
  input  logic            enable,
  output logic            k_hi,
  output logic            k_lo
);

  logic [DT_W-1:0] ramp_r;
  logic [DT_W-1:0] ramp_nxt_s;

  // Ramp next value: climb toward dead_cyc while commanded, otherwise decay to zero.
  always_comb begin
    ramp_nxt_s = ramp_r;
    if (cmd) begin
      if (ramp_r < dead_cyc) begin
        ramp_nxt_s = ramp_r + DT_W'(1);
      end else begin
        ramp_nxt_s = dead_cyc;
      end
    end else begin
      if (ramp_r != {DT_W{1'b0}}) begin
        ramp_nxt_s = ramp_r - DT_W'(1);
      end else begin
        ramp_nxt_s = {DT_W{1'b0}};
      end
    end
  end

  // Ramp and gate registers; a zero dead time disables both gates so they can never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_r <= {DT_W{1'b0}};
      k_hi   <= 1'b0;
      k_lo   <= 1'b0;
    end else begin
      ramp_r <= ramp_nxt_s;
      k_hi   <= (ramp_r == dead_cyc) && (dead_cyc != {DT_W{1'b0}});
      k_lo   <= (ramp_r == {DT_W{1'b0}}) && enable && (dead_cyc != {DT_W{1'b0}});
    end
  end

endmodule

// File: rtl/multi_pulse_gen.sv
// N-pulse gate-drive sequencer: synchronised trigger, burst FSM with phase counter and a
// frozen configuration snapshot, feeding a dead-time interlock for the complementary gates.
module multi_pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned           NPULSE_MAX = DEF_NPULSE_MAX,
  parameter int unsigned           CNT_W      = DEF_CNT_W,
  parameter int unsigned           DT_W       = DEF_DT_W,
  parameter logic [NPULSE_MAX-1:0] GATE_MASK  = DEF_GATE_MASK
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              trig,
  input  logic                              enable,
  input  logic                              abort,
  input  logic [$clog2(NPULSE_MAX+1)-1:0]   num_pulses,
  input  logic [NPULSE_MAX*CNT_W-1:0]       t_high,
  input  logic [CNT_W-1:0]                  t_low,
  input  logic [CNT_W-1:0]                  t_cool,
  input  logic [DT_W-1:0]                   dead_cyc,
  output logic                              k_hi,
  output logic                              k_lo,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(NPULSE_MAX)-1:0]     pulse_idx
);

  localparam int unsigned NP_W  = $clog2(NPULSE_MAX + 1);
  localparam int unsigned IDX_W = $clog2(NPULSE_MAX);

  logic                        trig_s1_r, trig_s2_r, trig_s3_r;
  logic                        trig_rise_s;
  state_e                      state_r, state_nxt_s;
  logic [CNT_W-1:0]            cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]            idx_r, idx_nxt_s;
  logic                        done_r, done_nxt_s;
  logic                        load_s;
  logic [NP_W-1:0]             n_r, n_clamp_s;
  logic [NPULSE_MAX*CNT_W-1:0] th_r;
  logic [CNT_W-1:0]            tl_r, tc_r;
  logic [DT_W-1:0]             dead_r;
  logic [CNT_W-1:0]            cur_len_s;
  logic                        phase_end_s;
  logic                        last_pulse_s;
  logic                        cmd_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Two-flop synchroniser plus a third flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1_r <= 1'b0;
      trig_s2_r <= 1'b0;
      trig_s3_r <= 1'b0;
    end else begin
      trig_s1_r <= trig;
      trig_s2_r <= trig_s1_r;
      trig_s3_r <= trig_s2_r;
    end
  end

  assign trig_rise_s  = trig_s2_r & ~trig_s3_r;
  assign n_clamp_s    = (num_pulses > NP_W'(NPULSE_MAX)) ? NP_W'(NPULSE_MAX) : num_pulses;
  assign last_pulse_s = (NP_W'(idx_r) + NP_W'(1)) >= n_r;
  // A zero-length phase behaves like a one-cycle phase.
  assign phase_end_s  = (cur_len_s <= CNT_W'(1)) || (cnt_r >= (cur_len_s - CNT_W'(1)));
  assign cmd_s        = (state_r == HIGH) && !(GATE_MASK[idx_r] && !enable);

  // Length of the phase currently being timed, taken from the frozen snapshot.
  always_comb begin
    cur_len_s = {CNT_W{1'b0}};
    case (state_r)
      HIGH:    cur_len_s = th_r[idx_r*CNT_W +: CNT_W];
      LOW:     cur_len_s = tl_r;
      COOL:    cur_len_s = tc_r;
      default: cur_len_s = {CNT_W{1'b0}};
    endcase
  end

  // Burst sequencing; abort overrides everything, including a coincident trigger.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    done_nxt_s  = 1'b0;
    load_s      = 1'b0;
    if (abort) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (trig_rise_s && (num_pulses != {NP_W{1'b0}})) begin
            load_s      = 1'b1;
            state_nxt_s = HIGH;
            cnt_nxt_s   = {CNT_W{1'b0}};
            idx_nxt_s   = {IDX_W{1'b0}};
          end else begin
            state_nxt_s = IDLE;
          end
        end
        HIGH: begin
          if (phase_end_s) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = last_pulse_s ? COOL : LOW;
          end else begin
            cnt_nxt_s = sat_inc(cnt_r);
          end
        end
        LOW: begin
          if (phase_end_s) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            idx_nxt_s   = idx_r + IDX_W'(1);
            state_nxt_s = HIGH;
          end else begin
            cnt_nxt_s = sat_inc(cnt_r);
          end
        end
        COOL: begin
          if (phase_end_s) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            cnt_nxt_s = sat_inc(cnt_r);
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // FSM state, phase counter, pulse index and done strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Configuration snapshot taken at burst start and held until the next accepted trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r    <= {NP_W{1'b0}};
      th_r   <= {(NPULSE_MAX*CNT_W){1'b0}};
      tl_r   <= {CNT_W{1'b0}};
      tc_r   <= {CNT_W{1'b0}};
      dead_r <= {DT_W{1'b0}};
    end else if (load_s) begin
      n_r    <= n_clamp_s;
      th_r   <= t_high;
      tl_r   <= t_low;
      tc_r   <= t_cool;
      dead_r <= dead_cyc;
    end
  end

  deadtime_ramp #(
    .DT_W(DT_W)
  ) u_ramp (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd      (cmd_s),
    .dead_cyc (dead_r),
    .enable   (enable),
    .k_hi     (k_hi),
    .k_lo     (k_lo)
  );

  assign busy      = (state_r != IDLE);
  assign done      = done_r;
  assign pulse_idx = idx_r;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// Self-checking bench for multi_pulse_gen: directed scenarios plus randomized bursts,
// compared cycle by cycle against a burst-schedule and dead-time-ramp reference.
module tb_multi_pulse_gen;
  import pulse_gen_pkg::*;

  localparam logic [3:0] GM = 4'b1110;

  logic         clk = 1'b0;
  logic         rst_n, trig, enable, abort;
  logic [2:0]   num_pulses;
  logic [127:0] t_high;
  logic [31:0]  t_low, t_cool;
  logic [9:0]   dead_cyc;
  logic         k_hi, k_lo, busy, done;
  logic [1:0]   pulse_idx;

  int n_tests = 0;
  int n_fail  = 0;

  int cfg_n, cfg_tl, cfg_tc, cfg_d, cfg_en;
  int cfg_th[4];

  always #5 clk = ~clk;

  multi_pulse_gen dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .enable(enable), .abort(abort),
    .num_pulses(num_pulses), .t_high(t_high), .t_low(t_low), .t_cool(t_cool),
    .dead_cyc(dead_cyc), .k_hi(k_hi), .k_lo(k_lo), .busy(busy), .done(done),
    .pulse_idx(pulse_idx)
  );

  task automatic apply_cfg();
    num_pulses = 3'(cfg_n);
    for (int i = 0; i < 4; i++) t_high[i*32 +: 32] = 32'(cfg_th[i]);
    t_low    = 32'(cfg_tl);
    t_cool   = 32'(cfg_tc);
    dead_cyc = 10'(cfg_d);
    enable   = (cfg_en != 0);
  endtask

  // One full burst: the schedule is built phase by phase, the ramp evolves by min/max rules.
  task automatic run_burst(input string name, input int abort_in, input bit retrig, input bit chk_width);
    int q_cmd[$], q_idx[$], widths[$], exp_w[$];
    int neff, d, w, len_l, L, L_eff, abort_at, r, run, first_rise, dones, cm;
    int e_busy, e_done, e_idx, e_khi, e_klo, e_ovl;
    logic exp_b, exp_d, exp_hi, exp_lo;
    int exp_i;
    neff = (cfg_n > 4) ? 4 : cfg_n;
    d = cfg_d;
    for (int i = 0; i < neff; i++) begin
      w = (cfg_th[i] < 1) ? 1 : cfg_th[i];
      cm = (GM[i] && cfg_en == 0) ? 0 : 1;
      for (int k = 0; k < w; k++) begin q_cmd.push_back(cm); q_idx.push_back(i); end
      if (cm == 1 && d != 0 && w >= d) exp_w.push_back(w - d + 1);
      if (i < neff - 1) begin
        len_l = (cfg_tl < 1) ? 1 : cfg_tl;
        for (int k = 0; k < len_l; k++) begin q_cmd.push_back(0); q_idx.push_back(i); end
      end
    end
    L = q_cmd.size() + ((cfg_tc < 1) ? 1 : cfg_tc);
    abort_at = (abort_in >= L) ? -1 : abort_in;
    L_eff = (abort_at >= 0) ? abort_at + 1 : L;
    e_busy = 0; e_done = 0; e_idx = 0; e_khi = 0; e_klo = 0; e_ovl = 0;
    r = 0; run = 0; first_rise = -1; dones = 0;

    @(negedge clk); apply_cfg(); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s latency: busy=%0b two clocks after trig, required 0", name, busy);
    end
    for (int c = 0; c <= L_eff + d + 6; c++) begin
      @(negedge clk);
      abort = (c == abort_at);
      trig  = retrig && (c == 4 || c == L - 3);
      exp_b = (c < L_eff);
      exp_d = (abort_at < 0) && (c == L);
      if (c < L_eff) exp_i = (c < q_idx.size()) ? q_idx[c] : neff - 1;
      else exp_i = (L_eff - 1 < q_idx.size()) ? q_idx[L_eff-1] : neff - 1;
      if (busy !== exp_b) e_busy++;
      if (done !== exp_d) e_done++;
      if (pulse_idx !== 2'(exp_i)) e_idx++;
      if (done === 1'b1) dones++;
      if (c >= 1) begin
        exp_hi = (r == d) && (d != 0);
        exp_lo = (r == 0) && (cfg_en != 0) && (d != 0);
        if (k_hi !== exp_hi) e_khi++;
        if (k_lo !== exp_lo) e_klo++;
        cm = (c - 1 < L_eff && c - 1 < q_cmd.size()) ? q_cmd[c-1] : 0;
        if (cm == 1) r = (r < d) ? r + 1 : d;
        else r = (r > 0) ? r - 1 : 0;
      end
      if (k_hi === 1'b1 && k_lo === 1'b1) e_ovl++;
      if (k_hi === 1'b1) begin
        if (first_rise < 0) first_rise = c;
        run++;
      end else if (run > 0) begin
        widths.push_back(run); run = 0;
      end
    end
    abort = 1'b0; trig = 1'b0;

    n_tests++; if (e_busy !== 0) begin n_fail++; $display("FAIL %s busy: %0d bad cycles, required 0", name, e_busy); end
    n_tests++; if (e_done !== 0) begin n_fail++; $display("FAIL %s done: %0d bad cycles, required 0", name, e_done); end
    n_tests++; if (e_idx !== 0) begin n_fail++; $display("FAIL %s pulse_idx: %0d bad cycles, required 0", name, e_idx); end
    n_tests++; if (e_khi !== 0) begin n_fail++; $display("FAIL %s k_hi: %0d bad cycles, required 0", name, e_khi); end
    n_tests++; if (e_klo !== 0) begin n_fail++; $display("FAIL %s k_lo: %0d bad cycles, required 0", name, e_klo); end
    n_tests++; if (e_ovl !== 0) begin n_fail++; $display("FAIL %s overlap: %0d cycles both gates on, required 0", name, e_ovl); end
    n_tests++;
    if (dones !== ((abort_at >= 0) ? 0 : 1)) begin
      n_fail++; $display("FAIL %s done_count: got %0d, required %0d", name, dones, (abort_at >= 0) ? 0 : 1);
    end
    if (chk_width) begin
      n_tests++;
      if (widths.size() !== exp_w.size()) begin
        n_fail++; $display("FAIL %s pulse_count: got %0d k_hi pulses, required %0d", name, widths.size(), exp_w.size());
      end else begin
        for (int i = 0; i < exp_w.size(); i++) begin
          n_tests++;
          if (widths[i] !== exp_w[i]) begin
            n_fail++; $display("FAIL %s width[%0d]: got %0d, required %0d", name, i, widths[i], exp_w[i]);
          end
        end
      end
      if (exp_w.size() > 0 && q_cmd[0] == 1 && cfg_th[0] >= d) begin
        n_tests++;
        if (first_rise !== d + 1) begin
          n_fail++; $display("FAIL %s k_hi_latency: rose at %0d, required %0d", name, first_rise, d + 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trig = 1'b0; abort = 1'b0; enable = 1'b1;
    cfg_n = 1; cfg_th = '{5, 5, 5, 5}; cfg_tl = 1; cfg_tc = 1; cfg_d = 1; cfg_en = 1;
    apply_cfg();
    #3;
    n_tests++;
    if ({k_hi, k_lo, busy, done, pulse_idx} !== 6'b0) begin
      n_fail++; $display("FAIL reset_state: got %b, required 000000", {k_hi, k_lo, busy, done, pulse_idx});
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if ({k_hi, k_lo, busy, done, pulse_idx} !== 6'b0) begin
      n_fail++; $display("FAIL reset_hold: got %b, required 000000", {k_hi, k_lo, busy, done, pulse_idx});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %0b, required 0", busy); end
  endtask

  task automatic test_double_pulse(input int en);
    cfg_n = 2; cfg_th = '{1200, 4000, 0, 0}; cfg_tl = 800; cfg_tc = 40;
    cfg_d = DEAD_7US; cfg_en = en;
    run_burst(en != 0 ? "double_en" : "double_noen", -1, 1'b0, 1'b1);
  endtask

  task automatic test_four_pulse();
    cfg_n = 4; cfg_th = '{10, 10, 10, 10}; cfg_tl = 6; cfg_tc = 10; cfg_d = 4; cfg_en = 1;
    run_burst("four_pulse", -1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    cfg_n = 2; cfg_th = '{10, 10, 0, 0}; cfg_tl = 8; cfg_tc = 12; cfg_d = 3; cfg_en = 1;
    run_burst("retrigger", -1, 1'b1, 1'b1);
  endtask

  task automatic test_abort();
    cfg_n = 2; cfg_th = '{20, 30, 0, 0}; cfg_tl = 10; cfg_tc = COOL_5S; cfg_d = 8; cfg_en = 1;
    run_burst("abort", 40, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int ab;
    for (int t = 0; t < 12; t++) begin
      cfg_n  = $urandom_range(1, 7);
      for (int i = 0; i < 4; i++) cfg_th[i] = $urandom_range(0, 30);
      cfg_tl = $urandom_range(0, 12);
      cfg_tc = $urandom_range(0, 10);
      cfg_d  = $urandom_range(0, 12);
      cfg_en = $urandom_range(0, 1);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : -1;
      run_burst($sformatf("random%0d", t), ab, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int e_b;
    cfg_n = 1; cfg_th = '{40, 0, 0, 0}; cfg_tl = 1; cfg_tc = 5; cfg_d = 5; cfg_en = 1;
    @(negedge clk); apply_cfg(); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++;
    if ({k_hi, busy} !== 2'b11) begin
      n_fail++; $display("FAIL pre_reset: k_hi,busy=%b, required 11", {k_hi, busy});
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({k_hi, k_lo, busy, done, pulse_idx} !== 6'b0) begin
      n_fail++; $display("FAIL reset_mid_pulse: got %b, required 000000", {k_hi, k_lo, busy, done, pulse_idx});
    end
    @(negedge clk); rst_n = 1'b1;
    cfg_n = 0; apply_cfg();
    @(negedge clk); trig = 1'b1;
    @(negedge clk); trig = 1'b0;
    e_b = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || k_hi !== 1'b0 || k_lo !== 1'b0) e_b++;
    end
    n_tests++;
    if (e_b !== 0) begin n_fail++; $display("FAIL zero_pulses: %0d cycles busy/gate active, required 0", e_b); end
  endtask

  initial begin
    t_high = 128'd0;
    test_reset();
    test_double_pulse(1);
    test_double_pulse(0);
    test_four_pulse();
    test_back_to_back();
    test_abort();
    test_random();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
